// File: rtl/demux_1x4_3bit_reg.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ready handshakes.
// Each lane is a one-entry holding register. The target lane comes from either
// {s1,s0} or an internal round-robin pointer. A blocked target stalls the input.
// The input never skips to another lane.
module demux_1x4_3bit_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s1,
    input  logic             s0,
    input  logic             auto_rr,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] W,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic             busy
);

    logic [WIDTH-1:0] lane_q [4];
    logic [1:0]       target;
    logic [3:0]       lane_free;
    logic             accept;

    // Target lane selection and input handshake; a lane draining this cycle counts as free
    always_comb begin
        target    = auto_rr ? rr_ptr : {s1, s0};
        lane_free = ~out_valid | out_ready;
        in_ready  = lane_free[target];
        accept    = in_valid && in_ready;
    end

    // Lane holding registers: load wins over drain, so a simultaneous drain/load keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                lane_q[k] <= '0;
            end
            out_valid <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (target == 2'(k))) begin
                    lane_q[k]    <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances only on an accept in auto mode; it is never cleared by a mode change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (accept && auto_rr) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

    // Lane data fan-out and busy flag, both taken straight from registered state
    always_comb begin
        X    = lane_q[0];
        Y    = lane_q[1];
        Z    = lane_q[2];
        W    = lane_q[3];
        busy = |out_valid;
    end

endmodule

// File: tb/tb_demux_1x4_3bit_reg.sv
// Bench for demux_1x4_3bit_reg: table-driven cycle vectors with a scoreboard queue,
// plus hand-written sequences for asynchronous reset and the first accept after reset.
module tb_demux_1x4_3bit_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       s1, s0;
    logic       auto_rr;
    logic [2:0] X, Y, Z, W;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    demux_1x4_3bit_reg #(.WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .s1(s1), .s0(s0), .auto_rr(auto_rr),
        .X(X), .Y(Y), .Z(Z), .W(W), .out_valid(out_valid),
        .out_ready(out_ready), .rr_ptr(rr_ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [2:0] d;
        logic [1:0] sel;
        logic       ar;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [3:0] e_vld;
        logic [2:0] ex, ey, ez, ew;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(logic iv, logic [2:0] d, logic [1:0] sel, logic ar,
                                logic [3:0] ordy, logic e_rdy, logic [3:0] e_vld,
                                logic [2:0] ex, logic [2:0] ey, logic [2:0] ez,
                                logic [2:0] ew, logic [1:0] e_ptr);
        vec_t v;
        v.iv = iv; v.d = d; v.sel = sel; v.ar = ar; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld;
        v.ex = ex; v.ey = ey; v.ez = ez; v.ew = ew; v.e_ptr = e_ptr;
        return v;
    endfunction

    task automatic chk(string name, int step, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic check_outputs(int step, vec_t e);
        chk("out_valid", step, int'(out_valid), int'(e.e_vld));
        chk("X", step, int'(X), int'(e.ex));
        chk("Y", step, int'(Y), int'(e.ey));
        chk("Z", step, int'(Z), int'(e.ez));
        chk("W", step, int'(W), int'(e.ew));
        chk("rr_ptr", step, int'(rr_ptr), int'(e.e_ptr));
        chk("busy", step, int'(busy), int'(|e.e_vld));
    endtask

    initial begin
        vec_t e;
        // iv d  sel  ar ordy     rdy vld      X  Y  Z  W  ptr
        // manual routing
        vecs.push_back(mk(1, 5, 2'b10, 0, 4'b1111, 1, 4'b0100, 0, 0, 5, 0, 0));
        vecs.push_back(mk(1, 2, 2'b01, 0, 4'b1111, 1, 4'b0010, 0, 2, 5, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 4'b1111, 1, 4'b0000, 0, 2, 5, 0, 0));
        // round-robin wrap
        vecs.push_back(mk(1, 1, 2'b00, 1, 4'b1111, 1, 4'b0001, 1, 2, 5, 0, 1));
        vecs.push_back(mk(1, 2, 2'b00, 1, 4'b1111, 1, 4'b0010, 1, 2, 5, 0, 2));
        vecs.push_back(mk(1, 3, 2'b00, 1, 4'b1111, 1, 4'b0100, 1, 2, 3, 0, 3));
        vecs.push_back(mk(1, 4, 2'b00, 1, 4'b1111, 1, 4'b1000, 1, 2, 3, 4, 0));
        vecs.push_back(mk(1, 5, 2'b00, 1, 4'b1111, 1, 4'b0001, 5, 2, 3, 4, 1));
        vecs.push_back(mk(0, 0, 2'b00, 1, 4'b1111, 1, 4'b0000, 5, 2, 3, 4, 1));
        // backpressure on W, then simultaneous drain/load
        vecs.push_back(mk(1, 6, 2'b11, 0, 4'b0111, 1, 4'b1000, 5, 2, 3, 6, 1));
        vecs.push_back(mk(1, 7, 2'b11, 0, 4'b0111, 0, 4'b1000, 5, 2, 3, 6, 1));
        vecs.push_back(mk(1, 7, 2'b11, 0, 4'b0111, 0, 4'b1000, 5, 2, 3, 6, 1));
        vecs.push_back(mk(1, 7, 2'b11, 0, 4'b1111, 1, 4'b1000, 5, 2, 3, 7, 1));
        vecs.push_back(mk(0, 0, 2'b11, 0, 4'b1111, 1, 4'b0000, 5, 2, 3, 7, 1));
        // lane independence: X stalled, Y/Z/W at full rate
        vecs.push_back(mk(1, 6, 2'b00, 0, 4'b1110, 1, 4'b0001, 6, 2, 3, 7, 1));
        vecs.push_back(mk(1, 1, 2'b01, 0, 4'b1110, 1, 4'b0011, 6, 1, 3, 7, 1));
        vecs.push_back(mk(1, 2, 2'b10, 0, 4'b1110, 1, 4'b0101, 6, 1, 2, 7, 1));
        vecs.push_back(mk(1, 3, 2'b11, 0, 4'b1110, 1, 4'b1001, 6, 1, 2, 3, 1));
        vecs.push_back(mk(1, 4, 2'b00, 0, 4'b1110, 0, 4'b0001, 6, 1, 2, 3, 1));
        // select changes while stalled: target follows new select
        vecs.push_back(mk(1, 4, 2'b01, 0, 4'b1110, 1, 4'b0011, 6, 4, 2, 3, 1));
        vecs.push_back(mk(0, 0, 2'b00, 0, 4'b1111, 1, 4'b0000, 6, 4, 2, 3, 1));
        // mode switch with rr_ptr=2 held through manual mode
        vecs.push_back(mk(1, 5, 2'b00, 1, 4'b1111, 1, 4'b0010, 6, 5, 2, 3, 2));
        vecs.push_back(mk(1, 1, 2'b00, 0, 4'b1111, 1, 4'b0001, 1, 5, 2, 3, 2));
        vecs.push_back(mk(1, 7, 2'b11, 0, 4'b1111, 1, 4'b1000, 1, 5, 2, 7, 2));
        vecs.push_back(mk(1, 3, 2'b00, 1, 4'b1111, 1, 4'b0100, 1, 5, 3, 7, 3));
        vecs.push_back(mk(0, 0, 2'b00, 1, 4'b1111, 1, 4'b0000, 1, 5, 3, 7, 3));

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; s1 = 1'b0; s0 = 1'b0;
        auto_rr = 1'b0; out_ready = 4'b0000;
        #1;
        e = mk(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0);
        check_outputs(-1, e);
        chk("in_ready_reset", -1, int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            {s1, s0}  = vecs[i].sel;
            auto_rr   = vecs[i].ar;
            out_ready = vecs[i].ordy;
            #1;
            chk("in_ready", i, int'(in_ready), int'(vecs[i].e_rdy));
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outputs(i, e);
        end

        // three full lanes, then asynchronous reset between edges
        auto_rr = 1'b0; out_ready = 4'b0000; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_data  = 3'(k + 2);
            {s1, s0} = 2'(k);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", 100, int'(out_valid), 4'b0111);
        chk("pre_reset_ptr", 100, int'(rr_ptr), 3);
        #2;
        rst_n = 1'b0;
        #1;
        e = mk(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0);
        check_outputs(101, e);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 102, int'(in_ready), 1);

        // first accept on the first edge after release
        in_valid = 1'b1; in_data = 3'd4; auto_rr = 1'b1; out_ready = 4'b1111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = mk(0, 0, 0, 0, 0, 1, 4'b0001, 4, 0, 0, 0, 1);
        check_outputs(103, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
